mul16_seq_ctrl: RTL and testbench

Multi-cycle sequencer for unsigned 16x16->32 shift-add multiplication. It time-shares one sixteen_bit_adder instance over 16 iterations. Sits beside the ALU and is started by the control unit for MUL-class instructions. The CPU stalls on busy and captures P on done.

---
 rtl/cpu16_pkg.sv | 19 +
 rtl/sixteen_bit_adder.sv | 26 ++
 rtl/mul16_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_mul16_seq_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// +-----------------------------------------------------------------------+
// | cpu16_pkg: shared encodings for the multi-cycle multiplier sequencer  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package cpu16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_e;

  localparam int MUL_ITER = 16;

endpackage

`default_nettype wire

// File: rtl/sixteen_bit_adder.sv
// +-----------------------------------------------------------------------+
// | sixteen_bit_adder: 16-bit adder with carry-out and signed overflow    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module sixteen_bit_adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Co,
  output logic        V
);

  logic [16:0] w_sum;

  assign w_sum = {1'b0, A} + {1'b0, B} + {16'd0, Cin};
  assign S     = w_sum[15:0];
  assign Co    = w_sum[16];
  // Signed overflow: operands agree in sign but the result does not.
  assign V     = (A[15] == B[15]) && (S[15] != A[15]);

endmodule

`default_nettype wire

// File: rtl/mul16_seq_ctrl.sv
// +-----------------------------------------------------------------------+
// | mul16_seq_ctrl: unsigned 16x16->32 shift-add multiplier, 16 iterations|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module mul16_seq_ctrl
  import cpu16_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P,
  output logic               ovf
);

  generate
    if (WIDTH != 16) begin : g_bad_width
      $error("mul16_seq_ctrl: WIDTH must be 16");
    end
  endgenerate

  mul_state_e r_state, w_state_nxt;

  logic [15:0] r_m, r_acc, r_q;
  logic [3:0]  r_count;
  logic [15:0] w_sum;
  logic        w_co, w_v;
  logic [15:0] w_sh_acc, w_sh_q;
  logic        w_skip, w_last;
  logic        unused_adder_v;

  sixteen_bit_adder u_adder (
    .A   (r_acc),
    .B   (r_m),
    .Cin (1'b0),
    .S   (w_sum),
    .Co  (w_co),
    .V   (w_v)
  );
  assign unused_adder_v = w_v;

  assign w_skip = SKIP_ZERO && ((A == '0) || (B == '0));
  assign w_last = (r_count == 4'(MUL_ITER - 1));

  always_comb begin
    w_sh_acc = r_acc;
    w_sh_q   = r_q;
    if (r_q[0]) {w_sh_acc, w_sh_q} = {w_co, w_sum, r_q[15:1]};
    else        {w_sh_acc, w_sh_q} = {1'b0, r_acc, r_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = w_skip ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_count <= '0;
      P       <= '0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_m     <= A;
            r_q     <= B;
            r_acc   <= '0;
            r_count <= '0;
            if (w_skip) begin
              P   <= '0;
              ovf <= 1'b0;
            end
          end
        end
        RUN: begin
          r_acc   <= w_sh_acc;
          r_q     <= w_sh_q;
          r_count <= r_count + 4'd1;
          if (w_last) begin
            P   <= {w_sh_acc, w_sh_q};
            ovf <= (w_sh_acc != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul16_seq_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_mul16_seq_ctrl: directed self-checking bench for mul16_seq_ctrl    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_mul16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start0 = 1'b0;
  logic [15:0] A_in = '0, B_in = '0;
  logic        busy1, done1, ovf1, busy0, done0, ovf0;
  logic [31:0] p1, p0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul16_seq_ctrl #(.WIDTH(16), .SKIP_ZERO(1'b1)) dut_skip (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(A_in), .B(B_in),
    .busy(busy1), .done(done1), .P(p1), .ovf(ovf1)
  );

  mul16_seq_ctrl #(.WIDTH(16), .SKIP_ZERO(1'b0)) dut_noskip (
    .clk(clk), .rst_n(rst_n), .start(start0), .A(A_in), .B(B_in),
    .busy(busy0), .done(done0), .P(p0), .ovf(ovf0)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges counted from the sampling edge of start up to the one after which done is seen.
  task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                        output int edges, output logic [31:0] p, output logic ov);
    @(negedge clk);
    A_in = a; B_in = b;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0;
    while (!(sel ? done1 : done0) && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    p  = sel ? p1 : p0;
    ov = sel ? ovf1 : ovf0;
  endtask

  initial begin
    int          edges, dones;
    logic [31:0] p;
    logic        ov;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_done", done1, 0);
    check_eq("rst_p",    p1,    0);
    check_eq("rst_ovf",  ovf1,  0);
    rst_n = 1'b1;

    run_op(1, 16'd3, 16'd5, edges, p, ov);
    check_eq("3x5_edges", edges, 17);
    check_eq("3x5_p",     p,     32'h0000000F);
    check_eq("3x5_ovf",   ov,    0);

    run_op(1, 16'hFFFF, 16'hFFFF, edges, p, ov);
    check_eq("ffff_edges", edges, 17);
    check_eq("ffff_p",     p,     32'hFFFE0001);
    check_eq("ffff_ovf",   ov,    1);

    run_op(1, 16'h1234, 16'h0000, edges, p, ov);
    check_eq("skipB_edges", edges, 1);
    check_eq("skipB_p",     p,     0);
    check_eq("skipB_ovf",   ov,    0);

    run_op(1, 16'h0000, 16'h0005, edges, p, ov);
    check_eq("skipA_edges", edges, 1);
    check_eq("skipA_p",     p,     0);

    run_op(0, 16'h1234, 16'h0000, edges, p, ov);
    check_eq("noskip_edges", edges, 17);
    check_eq("noskip_p",     p,     0);

    // start held high and operands changed while busy
    @(negedge clk);
    A_in = 16'd100; B_in = 16'd200; start1 = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    A_in = 16'd7; B_in = 16'd7;
    while (!done1 && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    start1 = 1'b0;
    check_eq("hold_edges", edges, 17);
    check_eq("hold_p",     p1,    32'd20000);
    check_eq("hold_ovf",   ovf1,  0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done1) dones++;
    end
    check_eq("hold_no_second_done", dones, 0);
    check_eq("hold_idle", busy1, 0);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    A_in = 16'h8000; B_in = 16'h0003; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("pre_rst_busy", busy1, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_busy", busy1, 0);
    check_eq("async_done", done1, 0);
    check_eq("async_p",    p1,    0);
    check_eq("async_ovf",  ovf1,  0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 16'd2, 16'd2, edges, p, ov);
    check_eq("post_rst_edges", edges, 17);
    check_eq("post_rst_p",     p,     32'd4);

    // Back-to-back: second start in the first IDLE cycle after done
    run_op(1, 16'd300, 16'd300, edges, p, ov);
    check_eq("b2b1_p",   p,  32'd90000);
    check_eq("b2b1_ovf", ov, 1);
    @(negedge clk);
    check_eq("b2b_idle_done", done1, 0);
    check_eq("b2b_idle_busy", busy1, 0);
    A_in = 16'd12; B_in = 16'd11; start1 = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (5) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    check_eq("b2b_p_held", p1,    32'd90000);
    check_eq("b2b_busy",   busy1, 1);
    while (!done1 && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    check_eq("b2b2_edges", edges, 17);
    check_eq("b2b2_p",     p1,    32'd132);
    check_eq("b2b2_ovf",   ovf1,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
